sram_vga_reader: RTL and testbench

- Downstream consumer of the SRAM frame-buffer writer.
- Once the writer has filled the 640x480 buffer, this block scans SRAM in raster order and generates 640x480@60 VGA timing.
- It issues one read per active pixel and presents registered pixel data aligned with hsync, vsync and blank_n.
- The top level muxes SRAM address and control between writer and reader; this block only drives read-side signals.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen.sv | 65 ++++++
 rtl/sram_vga_reader.sv | 143 ++++++++++++++
 tb/tb_sram_vga_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// +---------------------------------------------------------------+
// | vga_timing_pkg: default 640x480@60 timing and scan FSM states |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;
  localparam int CNT_W            = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +---------------------------------------------------------------+
// | vga_timing_gen: h/v raster counters, active flag, raw syncs   |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic origin,
  output logic frame_end
);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Counters park at the origin while idle so a new scan always begins at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_raw = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
  assign vsync_raw = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
  assign origin    = run && (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

`default_nettype wire

// File: rtl/sram_vga_reader.sv
// +---------------------------------------------------------------+
// | sram_vga_reader: raster SRAM scanout with 640x480@60 timing   |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module sram_vga_reader
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe_n,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_start,
  output logic              running
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  scan_state_e       state;
  logic              run;
  logic              active;
  logic              hsync_raw;
  logic              vsync_raw;
  logic              origin;
  logic              frame_end;
  logic [ADDR_W-1:0] addr;
  logic              active_d1;
  logic              hsync_d1;
  logic              vsync_d1;
  logic              fs_d1;

  assign run = (state == ST_SCAN);

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .origin    (origin),
    .frame_end (frame_end)
  );

  // Leaving SCAN is only honoured on the last clock of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      sram_oe_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_SCAN;
            running   <= 1'b1;
            sram_oe_n <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (frame_end && !enable) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            sram_oe_n <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          running   <= 1'b0;
          sram_oe_n <= 1'b1;
        end
      endcase
    end
  end

  // Linear address; sram_addr only follows it on active pixels so it holds through blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      sram_addr <= '0;
    end else if (!run) begin
      addr      <= '0;
    end else if (active) begin
      sram_addr <= addr;
      addr      <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
    end
  end

  // Two-stage delay so syncs, blank and frame_start line up with the returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_d1   <= 1'b0;
      hsync_d1    <= 1'b1;
      vsync_d1    <= 1'b1;
      fs_d1       <= 1'b0;
      pixel       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      active_d1   <= active;
      hsync_d1    <= hsync_raw;
      vsync_d1    <= vsync_raw;
      fs_d1       <= origin;
      pixel       <= active_d1 ? sram_dq_in : '0;
      hsync       <= hsync_d1;
      vsync       <= vsync_d1;
      blank_n     <= active_d1;
      frame_start <= fs_d1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_vga_reader.sv
// Directed bench: a default-timing instance for start-up/line timing and reset,
// plus a shrunken-timing instance so whole frames and the enable drop fit in a short run.
`default_nettype none

module tb_sram_vga_reader;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  } geo_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_d = 1'b0;
  logic en_s = 1'b0;

  logic [19:0] d_addr, s_addr;
  logic        d_oe_n, s_oe_n;
  logic [15:0] d_dq, s_dq, d_pix, s_pix;
  logic        d_hs, d_vs, d_bn, d_fs, d_run;
  logic        s_hs, s_vs, s_bn, s_fs, s_run;

  int   total = 0;
  int   bad   = 0;
  geo_t gd, gs;

  assign d_dq = d_addr[15:0] ^ 16'hA5A5;
  assign s_dq = s_addr[15:0] ^ 16'hA5A5;

  always #5 clk = ~clk;

  sram_vga_reader dut_d (
    .clk(clk), .rst(rst), .enable(en_d), .sram_addr(d_addr), .sram_oe_n(d_oe_n),
    .sram_dq_in(d_dq), .pixel(d_pix), .hsync(d_hs), .vsync(d_vs), .blank_n(d_bn),
    .frame_start(d_fs), .running(d_run)
  );

  sram_vga_reader #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .rst(rst), .enable(en_s), .sram_addr(s_addr), .sram_oe_n(s_oe_n),
    .sram_dq_in(s_dq), .pixel(s_pix), .hsync(s_hs), .vsync(s_vs), .blank_n(s_bn),
    .frame_start(s_fs), .running(s_run)
  );

  // Expected registered read address when stage 0 was at raster position q.
  function automatic logic [19:0] exp_addr(input int q, input geo_t g);
    int ht, vt, fr, line, col;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    if (q < 0) return 20'd0;
    fr = q % (ht * vt);
    line = fr / ht;
    col = fr % ht;
    if (line >= g.va) return 20'(g.va * g.ha - 1);
    if (col >= g.ha) return 20'(line * g.ha + g.ha - 1);
    return 20'(line * g.ha + col);
  endfunction

  // Expected aligned outputs for raster position q; positions >= stop_q are idle.
  task automatic model(input int q, input int stop_q, input geo_t g,
                       output logic vis, output logic hs, output logic vs,
                       output logic fs, output logic [15:0] px);
    int ht, vt, fr, line, col;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    vis = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; px = 16'h0;
    if (q >= 0 && q < stop_q) begin
      fr = q % (ht * vt);
      line = fr / ht;
      col = fr % ht;
      vis = (line < g.va) && (col < g.ha);
      hs = !((col >= g.ha + g.hfp) && (col < g.ha + g.hfp + g.hsw));
      vs = !((line >= g.va + g.vfp) && (line < g.va + g.vfp + g.vsw));
      fs = (fr == 0);
      if (vis) px = 16'(line * g.ha + col) ^ 16'hA5A5;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (d_run !== 1'b0) begin bad++; $display("FAIL reset.running got=%b want=0", d_run); end
    total++; if (d_oe_n !== 1'b1) begin bad++; $display("FAIL reset.sram_oe_n got=%b want=1", d_oe_n); end
    total++; if (d_addr !== 20'd0) begin bad++; $display("FAIL reset.sram_addr got=%h want=0", d_addr); end
    total++; if ({d_hs, d_vs, d_bn, d_fs} !== 4'b1100) begin
      bad++; $display("FAIL reset.syncs hs/vs/bn/fs got=%b want=1100", {d_hs, d_vs, d_bn, d_fs});
    end
    total++; if (d_pix !== 16'h0) begin bad++; $display("FAIL reset.pixel got=%h want=0", d_pix); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (d_run !== 1'b0 || s_run !== 1'b0) begin
      bad++; $display("FAIL reset.idle_hold running got=%b%b want=00", d_run, s_run);
    end
  endtask

  task automatic test_start;
    @(negedge clk); en_d = 1'b1;
    @(negedge clk);
    total++; if (d_run !== 1'b1) begin bad++; $display("FAIL start.running got=%b want=1", d_run); end
    total++; if (d_oe_n !== 1'b0) begin bad++; $display("FAIL start.sram_oe_n got=%b want=0", d_oe_n); end
    total++; if (d_bn !== 1'b0) begin bad++; $display("FAIL start.blank_early got=%b want=0", d_bn); end
    @(negedge clk);
    total++; if (d_addr !== 20'd0) begin bad++; $display("FAIL start.addr0 got=%h want=0", d_addr); end
    total++; if (d_fs !== 1'b0) begin bad++; $display("FAIL start.fs_early got=%b want=0", d_fs); end
    @(negedge clk);
    total++; if (d_addr !== 20'd1) begin bad++; $display("FAIL start.addr1 got=%h want=1", d_addr); end
    total++; if ({d_bn, d_fs} !== 2'b11) begin bad++; $display("FAIL start.first_pixel bn/fs got=%b want=11", {d_bn, d_fs}); end
    total++; if (d_pix !== 16'hA5A5) begin bad++; $display("FAIL start.pixel0 got=%h want=a5a5", d_pix); end
    @(negedge clk);
    total++; if (d_fs !== 1'b0) begin bad++; $display("FAIL start.fs_pulse got=%b want=0", d_fs); end
    total++; if (d_pix !== 16'hA5A4) begin bad++; $display("FAIL start.pixel1 got=%h want=a5a4", d_pix); end
    total++; if (d_addr !== 20'd2) begin bad++; $display("FAIL start.addr2 got=%h want=2", d_addr); end
  endtask

  // Continues the default scan from sample 5 to cover line 0, line 1 and into line 2.
  task automatic test_first_line;
    int e_a = 0, e_bn = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_px = 0, first_a = -1;
    logic vis, hs, vs, fs;
    logic [15:0] px;
    logic [19:0] ea, got_a, want_a;
    for (int n = 5; n <= 1700; n++) begin
      @(negedge clk);
      ea = exp_addr(n - 2, gd);
      model(n - 3, 1 << 30, gd, vis, hs, vs, fs, px);
      if (d_addr !== ea) begin
        e_a++;
        if (first_a < 0) begin first_a = n; got_a = d_addr; want_a = ea; end
      end
      if (d_bn !== vis) e_bn++;
      if (d_hs !== hs) e_hs++;
      if (d_vs !== vs) e_vs++;
      if (d_fs !== fs) e_fs++;
      if (d_pix !== px) e_px++;
    end
    total++; if (e_a !== 0) begin
      bad++; $display("FAIL line.sram_addr errors=%0d want=0 (first n=%0d got %h want %h)", e_a, first_a, got_a, want_a);
    end
    total++; if (e_bn !== 0) begin bad++; $display("FAIL line.blank_n errors=%0d want=0", e_bn); end
    total++; if (e_hs !== 0) begin bad++; $display("FAIL line.hsync errors=%0d want=0", e_hs); end
    total++; if (e_vs !== 0) begin bad++; $display("FAIL line.vsync errors=%0d want=0", e_vs); end
    total++; if (e_fs !== 0) begin bad++; $display("FAIL line.frame_start errors=%0d want=0", e_fs); end
    total++; if (e_px !== 0) begin bad++; $display("FAIL line.pixel errors=%0d want=0", e_px); end
  endtask

  task automatic test_reset_mid;
    #2 rst = 1'b1;
    #1;
    total++; if (d_run !== 1'b0) begin bad++; $display("FAIL midreset.running got=%b want=0", d_run); end
    total++; if (d_oe_n !== 1'b1) begin bad++; $display("FAIL midreset.sram_oe_n got=%b want=1", d_oe_n); end
    total++; if (d_addr !== 20'd0) begin bad++; $display("FAIL midreset.sram_addr got=%h want=0", d_addr); end
    total++; if ({d_hs, d_vs, d_bn, d_fs} !== 4'b1100) begin
      bad++; $display("FAIL midreset.syncs hs/vs/bn/fs got=%b want=1100", {d_hs, d_vs, d_bn, d_fs});
    end
    total++; if (d_pix !== 16'h0) begin bad++; $display("FAIL midreset.pixel got=%h want=0", d_pix); end
    @(negedge clk); rst = 1'b0; en_d = 1'b0;
  endtask

  task automatic test_restart;
    @(negedge clk); en_d = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (d_addr !== 20'd0) begin bad++; $display("FAIL restart.addr0 got=%h want=0", d_addr); end
    @(negedge clk);
    total++; if ({d_addr, d_fs} !== {20'd1, 1'b1}) begin
      bad++; $display("FAIL restart.origin addr/fs got=%h/%b want=1/1", d_addr, d_fs);
    end
    en_d = 1'b0;
  endtask

  // Small geometry: 30x15 raster, 450 clocks/frame, 128 pixels. Enable drops in frame 2, line 4.
  task automatic test_full_frame;
    int e_a = 0, e_bn = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_px = 0, e_run = 0, e_per = 0;
    int fs_cnt = 0, last_fs = -1;
    logic vis, hs, vs, fs;
    logic [15:0] px;
    @(negedge clk); en_s = 1'b1;
    for (int n = 1; n <= 1420; n++) begin
      @(negedge clk);
      if (n <= 1351 && s_addr !== exp_addr(n - 2, gs)) e_a++;
      model(n - 3, 1350, gs, vis, hs, vs, fs, px);
      if (s_bn !== vis) e_bn++;
      if (s_hs !== hs) e_hs++;
      if (s_vs !== vs) e_vs++;
      if (s_fs !== fs) e_fs++;
      if (s_pix !== px) e_px++;
      if (s_run !== (n <= 1350) || s_oe_n !== (n > 1350)) e_run++;
      if (s_fs === 1'b1) begin
        if (last_fs >= 0 && n - last_fs != 450) e_per++;
        last_fs = n;
        fs_cnt++;
      end
      if (n == 1020) en_s = 1'b0;
    end
    total++; if (e_a !== 0) begin bad++; $display("FAIL frame.sram_addr errors=%0d want=0", e_a); end
    total++; if (e_bn !== 0) begin bad++; $display("FAIL frame.blank_n errors=%0d want=0", e_bn); end
    total++; if (e_hs !== 0) begin bad++; $display("FAIL frame.hsync errors=%0d want=0", e_hs); end
    total++; if (e_vs !== 0) begin bad++; $display("FAIL frame.vsync errors=%0d want=0", e_vs); end
    total++; if (e_fs !== 0) begin bad++; $display("FAIL frame.frame_start errors=%0d want=0", e_fs); end
    total++; if (e_px !== 0) begin bad++; $display("FAIL frame.pixel errors=%0d want=0", e_px); end
    total++; if (e_run !== 0) begin bad++; $display("FAIL frame.running_oe errors=%0d want=0", e_run); end
    total++; if (e_per !== 0 || fs_cnt !== 3) begin
      bad++; $display("FAIL frame.fs_period period_errors=%0d pulses=%0d want 0 and 3", e_per, fs_cnt);
    end
  endtask

  initial begin
    gd = '{640, 16, 96, 48, 480, 10, 2, 33};
    gs = '{16, 4, 6, 4, 8, 2, 2, 3};
    test_reset();
    test_start();
    test_first_line();
    test_reset_mid();
    test_restart();
    test_full_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
